regfile_mp: RTL and testbench

Parametrised multi-read-port register file: the next-generation register storage for the R-type datapath. One write port and NUM_RD registered read ports, configurable width and depth, and an optional hardwired-zero register. The array is cleared by a sequential sweep after reset or on request instead of by a wide reset. Reads carry a valid flag; writes issued while the block is busy are flagged as dropped.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 55 +++++
 rtl/regfile_mp.sv | 108 ++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-read-port register file.
//   regfile_state_t : controller state (ST_IDLE, ST_CLEAR)
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default geometry
//   slice_lo()      : low bit index of lane k in a packed bus of w-bit lanes
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } regfile_state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
//   clk, rst  : clock, asynchronous active-low reset
//   fire      : capture strobe (read enabled and array idle)
//   addr      : read address for this port
//   mem_data  : raw array word at addr
//   wr_fire   : a write is performed this edge (REGFILE_BYPASS_EN only)
//   wr_addr   : address of that write (REGFILE_BYPASS_EN only)
//   wr_data   : data of that write (REGFILE_BYPASS_EN only)
//   data      : registered read data, holds when fire is low
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data
);

  logic              masked;
  logic [DATA_W-1:0] next_data;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    masked    = (int'(addr) >= DEPTH) || ((ZERO_REG != 0) && (addr == '0));
    next_data = mem_data;
`ifdef REGFILE_BYPASS_EN
    // wr_fire already excludes out-of-range and zero-register writes.
    if (wr_fire && (wr_addr == addr)) next_data = wr_data;
`endif
    if (masked) next_data = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (fire) begin
      data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: one write port, NUM_RD registered read ports, array cleared by a
// sequential sweep after reset or on clr_req.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
//   clk, rst : clock, asynchronous active-low reset
//   clr_req  : request a clear sweep (ignored while one is running)
//   busy     : sweep in progress
//   wr_en, wr_addr, wr_data : write port
//   wr_drop  : one-cycle pulse, a write was lost to a sweep
//   rd_en    : read strobe shared by all ports
//   rd_addr  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  : packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_valid : one-cycle pulse, rd_data updated
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid
);

  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  regfile_state_t    state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr_ok;
  logic              wr_fire;
  logic              rd_fire;

  assign idle    = (state == ST_IDLE);
  assign busy    = !idle;
  // Out-of-range and zero-register writes are dropped silently, without wr_drop.
  assign wr_ok   = (int'(wr_addr) < DEPTH) && !((ZERO_REG != 0) && (wr_addr == '0));
  // A clear request in the same cycle wins over the write.
  assign wr_fire = idle && !clr_req && wr_en && wr_ok;
  assign rd_fire = idle && rd_en;

  // NOTE: the array is deliberately not reset; the clear sweep zeroes it, and the reset branch leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      wr_drop  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wr_drop  <= wr_en && (!idle || clr_req);
      rd_valid <= rd_fire;
      if (idle) begin
        if (clr_req) begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
        end else if (wr_fire) begin
          mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
      end else begin
        mem[clr_cnt[IDX_W-1:0]] <= '0;
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ENTRY) state <= ST_IDLE;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_data;

    assign addr     = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
    // Low index bits only; out-of-range addresses are masked inside the port.
    assign mem_data = mem[addr[IDX_W-1:0]];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .fire     (rd_fire),
      .addr     (addr),
      .mem_data (mem_data),
`ifdef REGFILE_BYPASS_EN
      .wr_fire  (wr_fire),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`endif
      .data     (rd_data[slice_lo(k, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Main instance uses default geometry (32 x 32, 2 ports, zero register);
// a second instance uses ADDR_W = 6 with DEPTH = 32 to reach out-of-range addresses.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              clr_req = 1'b0;
  logic              wr_en   = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rd_en   = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic              busy;
  logic              wr_drop;
  logic              rd_valid;

  logic              b_clr_req = 1'b0;
  logic              b_wr_en   = 1'b0;
  logic [5:0]        b_wr_addr = '0;
  logic [DW-1:0]     b_wr_data = '0;
  logic              b_rd_en   = 1'b0;
  logic [NRD*6-1:0]  b_rd_addr = '0;
  logic [NRD*DW-1:0] b_rd_data;
  logic              b_busy;
  logic              b_wr_drop;
  logic              b_rd_valid;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(6), .DEPTH(32), .NUM_RD(NRD), .ZERO_REG(1)) dut_wide (
    .clk(clk), .rst(rst), .clr_req(b_clr_req), .busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_drop(b_wr_drop),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: array contents as the spec defines them, the last value
  // each port returned, and how many sweep edges remain.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rd  [NRD];
  int            sweep_left;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return (a == '0) ? '0 : ref_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int k = 0; k < NRD; k++) exp_rd[k] = '0;
    sweep_left = DEPTH;
  endtask

  // Drive one cycle on the main instance, predict its outcome, advance one edge, compare.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic cr, input string tag);
    logic          exp_valid;
    logic          exp_drop;
    logic [AW-1:0] ra [NRD];
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    clr_req = cr;
    ra[0] = a0;
    ra[1] = a1;
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    if (sweep_left == 0) begin
      if (re) begin
        exp_valid = 1'b1;
        for (int k = 0; k < NRD; k++) begin
          exp_rd[k] = ref_read(ra[k]);
`ifdef REGFILE_BYPASS_EN
          if (we && !cr && (wa != '0) && (ra[k] == wa)) exp_rd[k] = wd;
`endif
        end
      end
      if (we && cr) exp_drop = 1'b1;
      else if (we && (wa != '0)) ref_mem[wa] = wd;
      if (cr) begin
        // Reads are blocked until the sweep ends, so the array is simply zero from here.
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        sweep_left = DEPTH;
      end
    end else begin
      exp_drop = we;
      sweep_left--;
    end
    @(posedge clk);
    #1;
    check({tag, ".rd_valid"}, rd_valid, exp_valid);
    check({tag, ".wr_drop"}, wr_drop, exp_drop);
    check({tag, ".busy"}, busy, sweep_left != 0);
    for (int k = 0; k < NRD; k++) check($sformatf("%s.rd_data%0d", tag, k), port(k), exp_rd[k]);
  endtask

  task automatic idle_cycle(input string tag);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, tag);
  endtask

  // Count edges until busy falls, bounded so a stuck sweep still reaches the summary.
  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      cycle(1'b0, '0, '0, (i % 7) == 3, AW'(i), AW'(i + 1), (i % 11) == 5, tag);
      n++;
    end
    check({tag, ".edges"}, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] same_exp;
    int            n;

    // Reset held: controller parked in the sweep state, outputs cleared.
    #12;
    check("rst.busy", busy, 1'b1);
    check("rst.rd_valid", rd_valid, 1'b0);
    check("rst.wr_drop", wr_drop, 1'b0);
    check("rst.rd_data", rd_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    count_sweep("rst_sweep");

    // Every entry reads zero after the sweep.
    for (int i = 0; i < DEPTH; i += 2) cycle(1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1), 1'b0, "sweep_read");

    // Basic write then dual-port read of the same entry.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, "wr5");
    cycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd5, 1'b0, "rd5");
    check("rd5.p0_const", port(0), 32'hDEAD_BEEF);
    check("rd5.p1_const", port(1), 32'hDEAD_BEEF);

    // Zero register ignores writes silently.
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0, "wr0");
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 5'd5, 1'b0, "rd0");
    check("rd0.p0_const", port(0), 32'h0);

    // Same-edge write and read of one address.
    cycle(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, '0, 1'b0, "wr7_old");
    cycle(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd3, 1'b0, "same_edge");
`ifdef REGFILE_BYPASS_EN
    same_exp = 32'h1234_5678;
`else
    same_exp = 32'hA5A5_A5A5;
`endif
    check("same_edge.p0_const", port(0), same_exp);
    cycle(1'b0, '0, '0, 1'b1, 5'd3, 5'd7, 1'b0, "after_same");
    check("after_same.p1_const", port(1), 32'h1234_5678);

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      wa = AW'($urandom_range(0, DEPTH - 1));
      a0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), a0, a1,
            $urandom_range(0, 39) == 0, "rand");
    end
    for (int i = 0; i < 100 && sweep_left > 0; i++) idle_cycle("drain");

    // Wide instance: addresses at or above DEPTH are ignored / read as zero.
    b_wr_en = 1'b1; b_wr_addr = 6'd8; b_wr_data = 32'h0000_2222;
    idle_cycle("wide_wr8");
    check("wide_wr8.wr_drop", b_wr_drop, 1'b0);
    b_wr_addr = 6'd40; b_wr_data = 32'h0000_1111;
    idle_cycle("wide_wr40");
    check("wide_wr40.wr_drop", b_wr_drop, 1'b0);
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = {6'd8, 6'd40};
    idle_cycle("wide_rd");
    check("wide_rd.rd_valid", b_rd_valid, 1'b1);
    check("wide_rd.addr40", b_rd_data[0 +: DW], 32'h0);
    check("wide_rd.addr8", b_rd_data[DW +: DW], 32'h0000_2222);
    b_rd_en = 1'b0;

    // Clear request collides with a write: write lost, full sweep, entry reads zero.
    cycle(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0, 1'b0, "pre9");
    cycle(1'b1, 5'd9, 32'h0000_0077, 1'b0, '0, '0, 1'b1, "clr_wr");
    count_sweep("clr_sweep");
    cycle(1'b0, '0, '0, 1'b1, 5'd9, 5'd1, 1'b0, "rd9");
    check("rd9.p0_const", port(0), 32'h0);

    // Hold behaviour with rd_en low.
    cycle(1'b1, 5'd3, 32'h0000_0055, 1'b0, '0, '0, 1'b0, "wr3");
    cycle(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 1'b0, "rd3");
    cycle(1'b0, '0, '0, 1'b0, 5'd9, 5'd9, 1'b0, "hold");
    check("hold.p0_const", port(0), 32'h0000_0055);
    check("hold.valid_const", rd_valid, 1'b0);

    // Reset asserted at sweep entry 10, then a full sweep after release.
    cycle(1'b1, 5'd20, 32'h0000_0ABC, 1'b0, '0, '0, 1'b0, "wr20");
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "clr2");
    for (int i = 0; i < 10; i++) idle_cycle("sweep10");
    rst = 1'b0;
    #2;
    check("midrst.busy", busy, 1'b1);
    check("midrst.rd_data", rd_data, '0);
    check("midrst.rd_valid", rd_valid, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_edge.busy", busy, 1'b1);
    check("midrst_edge.rd_data", rd_data, '0);
    rst = 1'b1;
    model_reset();
    count_sweep("rst2_sweep");
    n = 0;
    cycle(1'b0, '0, '0, 1'b1, 5'd20, 5'd3, 1'b0, "rd20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
